writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: alu_valid in 1, alu_rd in 5, alu_data in 32, alu_ready out 1  ALU result channel.
REQ-004 SHALL have ports: ld_valid in 1, ld_rd in 5, ld_data in 32, ld_ready out 1  load result channel.
REQ-005 SHALL have ports: Write out 1, D_address out 5, D_data out 32  register-file write port drive.
REQ-006 SHALL have port: idle  out  1  high when both queues are empty and Write is low.
REQ-007 SHALL have parameter: DEPTH, default 2, entries per source queue (power of two, 2..8).

Function
REQ-008 SHALL accept a source transfer on a rising edge where valid and ready are both high.
REQ-009 SHALL drive each ready combinationally high iff that source's queue count is less than DEPTH.
REQ-010 SHALL discard an accepted transfer whose rd is 0 without enqueuing it; the handshake still completes.
REQ-011 SHALL hold each source in its own FIFO of {rd, data}, with wrapping read/write pointers and a count register.
REQ-012 SHALL on every edge pop at most one entry in total, chosen by the arbiter, and register it into Write/D_address/D_data with Write=1.
REQ-013 SHALL register Write=0 on an edge where both queues are empty; D_address/D_data hold their last values.
REQ-014 SHALL arbitrate round-robin when both queues are non-empty: a last-grant flop selects the source not granted last; it resets to ALU, so the first contention goes to load.
REQ-015 SHALL grant the only non-empty queue when exactly one is non-empty, and update last-grant on every grant.
REQ-016 SHALL have latency: an entry accepted at edge k into an empty queue with no contention appears with Write=1 after edge k+1.
REQ-017 SHALL only pop entries present before the edge: simultaneous push and pop on one queue leaves count unchanged and pointers both advanced.
REQ-018 SHALL preserve per-source order; no ordering is guaranteed between sources.
REQ-019 SHALL never drive Write=1 with D_address=0.

Reset
REQ-020 SHALL on rst clear both queue counts and pointers, Write=0, D_address=0, D_data=0, and last-grant=ALU, immediately and regardless of clk.
REQ-021 SHALL discard queued entries when rst asserts mid-operation; no write is emitted for them after release.
REQ-022 SHALL drive alu_ready=ld_ready=1 and idle=1 while rst is high and on the first cycle after release.

Configuration
REQ-023 SHALL support the macro WB_BYPASS_EN; when defined, it adds inputs A_address[4:0], B_address[4:0] and outputs A_fwd, A_fwd_data[31:0], B_fwd, B_fwd_data[31:0].
REQ-024 SHALL with WB_BYPASS_EN drive A_fwd combinationally = Write & (A_address==D_address) & (A_address!=0), A_fwd_data=D_data; B likewise.
REQ-025 SHALL without WB_BYPASS_EN omit those ports and logic entirely; all other behaviour is identical.

Verification
REQ-026 SHALL cover: ALU push rd=5 data=0x12345678 at edge 1, load idle -> Write=1, D_address=5, D_data=0x12345678 after edge 2 only; Write=0 after edge 3.
REQ-027 SHALL cover: both channels push every cycle (ALU rd=1.., load rd=17..) -> grants alternate load, ALU, load, ...; both readys toggle as queues fill; no entry lost or reordered per source.
REQ-028 SHALL cover: load push rd=0 data=0xDEADBEEF -> ld_ready handshake completes, no Write ever asserted, idle stays 1.
REQ-029 SHALL cover: fill ALU queue to DEPTH with load idle -> alu_ready=0 exactly while count==DEPTH; drain order matches push order.
REQ-030 SHALL cover: rst pulsed mid-cycle with 2 entries queued -> Write=0, queues empty, ready=1 immediately; no stale writes after release.
REQ-031 SHALL cover: with WB_BYPASS_EN, Write=1 D_address=9 D_data=0xA5A5A5A5, A_address=9, B_address=0 -> A_fwd=1, A_fwd_data=0xA5A5A5A5, B_fwd=0.

Source files
------------

// File: rtl/writeback_arbiter.sv
// ============================================================================
// Module   : writeback_arbiter
// Purpose  : Two-source (ALU / load) result queues with round-robin arbitration
//            onto a single registered register-file write port.
//            Optional WB_BYPASS_EN adds two combinational forwarding taps.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module writeback_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        Write,
    output logic [4:0]  D_address,
    output logic [31:0] D_data,
    output logic        idle
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]  A_address,
    input  logic [4:0]  B_address,
    output logic        A_fwd,
    output logic [31:0] A_fwd_data,
    output logic        B_fwd,
    output logic [31:0] B_fwd_data
`endif
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LD  = 1'b1
    } grant_t;

    // Index 0 is the ALU channel, index 1 the load channel.
    logic [1:0]        w_in_valid;
    logic [1:0][4:0]   w_in_rd;
    logic [1:0][31:0]  w_in_data;
    logic [1:0]        w_ready;
    logic [1:0]        w_nonempty;
    logic [1:0]        w_pop;
    logic [1:0][4:0]   w_head_rd;
    logic [1:0][31:0]  w_head_data;

    assign w_in_valid = {ld_valid, alu_valid};
    assign w_in_rd    = {ld_rd, alu_rd};
    assign w_in_data  = {ld_data, alu_data};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_src
            logic [4:0]         r_mem_rd   [DEPTH];
            logic [31:0]        r_mem_data [DEPTH];
            logic [c_ptr_w-1:0] r_wptr;
            logic [c_ptr_w-1:0] r_rptr;
            logic [c_cnt_w-1:0] r_count;
            logic               w_push;

            assign w_ready[i]     = (r_count < c_depth);
            assign w_nonempty[i]  = (r_count != '0);
            // rd=0 completes the handshake but is dropped here.
            assign w_push         = w_in_valid[i] & w_ready[i] & (w_in_rd[i] != 5'd0);
            assign w_head_rd[i]   = r_mem_rd[r_rptr];
            assign w_head_data[i] = r_mem_data[r_rptr];

            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem_rd[r_wptr]   <= w_in_rd[i];
                    r_mem_data[r_wptr] <= w_in_data[i];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push) begin
                        r_wptr <= r_wptr + 1'b1;
                    end
                    if (w_pop[i]) begin
                        r_rptr <= r_rptr + 1'b1;
                    end
                    case ({w_push, w_pop[i]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    assign alu_ready = w_ready[0];
    assign ld_ready  = w_ready[1];

    grant_t r_last;
    grant_t w_grant;
    logic   w_grant_valid;
    logic   w_sel;

    always_comb begin
        w_grant       = GNT_ALU;
        w_grant_valid = 1'b0;
        w_pop         = 2'b00;
        // Contention goes to whichever source did not win last time.
        if (w_nonempty[0] && w_nonempty[1]) begin
            w_grant       = (r_last == GNT_ALU) ? GNT_LD : GNT_ALU;
            w_grant_valid = 1'b1;
        end else if (w_nonempty[0]) begin
            w_grant       = GNT_ALU;
            w_grant_valid = 1'b1;
        end else if (w_nonempty[1]) begin
            w_grant       = GNT_LD;
            w_grant_valid = 1'b1;
        end
        if (w_grant_valid) begin
            w_pop[w_sel] = 1'b1;
        end
    end

    assign w_sel = (w_grant == GNT_LD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last    <= GNT_ALU;
            Write     <= 1'b0;
            D_address <= 5'd0;
            D_data    <= 32'd0;
        end else if (w_grant_valid) begin
            r_last    <= w_grant;
            Write     <= 1'b1;
            D_address <= w_head_rd[w_sel];
            D_data    <= w_head_data[w_sel];
        end else begin
            Write     <= 1'b0;
        end
    end

    assign idle = ~w_nonempty[0] & ~w_nonempty[1] & ~Write;

`ifdef WB_BYPASS_EN
    assign A_fwd      = Write & (A_address == D_address) & (A_address != 5'd0);
    assign A_fwd_data = D_data;
    assign B_fwd      = Write & (B_address == D_address) & (B_address != 5'd0);
    assign B_fwd_data = D_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// ============================================================================
// Module   : tb_writeback_arbiter
// Purpose  : Directed self-checking bench for writeback_arbiter (DEPTH=2).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        alu_ready;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_rd = 5'd0;
    logic [31:0] ld_data = 32'd0;
    logic        ld_ready;
    logic        Write;
    logic [4:0]  D_address;
    logic [31:0] D_data;
    logic        idle;
`ifdef WB_BYPASS_EN
    logic [4:0]  A_address = 5'd0;
    logic [4:0]  B_address = 5'd0;
    logic        A_fwd;
    logic [31:0] A_fwd_data;
    logic        B_fwd;
    logic [31:0] B_fwd_data;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    writeback_arbiter #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .Write(Write), .D_address(D_address), .D_data(D_data), .idle(idle)
`ifdef WB_BYPASS_EN
        ,
        .A_address(A_address), .B_address(B_address),
        .A_fwd(A_fwd), .A_fwd_data(A_fwd_data),
        .B_fwd(B_fwd), .B_fwd_data(B_fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && Write) begin
            check_eq("wr_addr_nonzero", {31'd0, D_address != 5'd0}, 32'd1);
        end
    end

    // Hand-computed round-robin schedule for both channels pushing every cycle.
    logic       exp_ra [0:7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_rl [0:7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0] exp_wa [0:9] = '{5'd17, 5'd1, 5'd18, 5'd2, 5'd19, 5'd3, 5'd20, 5'd4, 5'd21, 5'd5};

    initial begin
        logic [4:0]  a_rd;
        logic [4:0]  l_rd;
        logic        acc_a;
        logic        acc_l;
        logic [31:0] exp_d;

        #12;
        check_eq("rst_write", {31'd0, Write}, 32'd0);
        check_eq("rst_daddr", {27'd0, D_address}, 32'd0);
        check_eq("rst_ddata", D_data, 32'd0);
        check_eq("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        check_eq("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        check_eq("rst_idle", {31'd0, idle}, 32'd1);
        #10;
        rst = 1'b0;
        #1;
        check_eq("rel_alu_ready", {31'd0, alu_ready}, 32'd1);
        check_eq("rel_ld_ready", {31'd0, ld_ready}, 32'd1);
        check_eq("rel_idle", {31'd0, idle}, 32'd1);

        // Both channels push continuously; first contention must go to load.
        a_rd  = 5'd1;
        l_rd  = 5'd17;
        acc_a = 1'b0;
        acc_l = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            if (e <= 8) begin
                alu_valid = 1'b1;
                alu_rd    = a_rd;
                alu_data  = 32'hA000_0000 | {27'd0, a_rd};
                ld_valid  = 1'b1;
                ld_rd     = l_rd;
                ld_data   = 32'hB000_0000 | {27'd0, l_rd};
                check_eq($sformatf("rr_alu_ready_e%0d", e), {31'd0, alu_ready}, {31'd0, exp_ra[e-1]});
                check_eq($sformatf("rr_ld_ready_e%0d", e), {31'd0, ld_ready}, {31'd0, exp_rl[e-1]});
                acc_a = alu_ready;
                acc_l = ld_ready;
            end else begin
                alu_valid = 1'b0;
                ld_valid  = 1'b0;
                acc_a     = 1'b0;
                acc_l     = 1'b0;
            end
            tick();
            if (acc_a) a_rd = a_rd + 5'd1;
            if (acc_l) l_rd = l_rd + 5'd1;
            if (e == 1) begin
                check_eq("rr_write_e1", {31'd0, Write}, 32'd0);
            end else begin
                exp_d = ((exp_wa[e-2] >= 5'd17) ? 32'hB000_0000 : 32'hA000_0000) | {27'd0, exp_wa[e-2]};
                check_eq($sformatf("rr_write_e%0d", e), {31'd0, Write}, 32'd1);
                check_eq($sformatf("rr_daddr_e%0d", e), {27'd0, D_address}, {27'd0, exp_wa[e-2]});
                check_eq($sformatf("rr_ddata_e%0d", e), D_data, exp_d);
            end
        end
        tick();
        check_eq("rr_drained_write", {31'd0, Write}, 32'd0);
        check_eq("rr_drained_idle", {31'd0, idle}, 32'd1);

        // Single ALU push: visible only after the following edge.
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'h1234_5678;
        tick();
        alu_valid = 1'b0;
        check_eq("lat_write_e1", {31'd0, Write}, 32'd0);
        check_eq("lat_idle_e1", {31'd0, idle}, 32'd0);
        tick();
        check_eq("lat_write_e2", {31'd0, Write}, 32'd1);
        check_eq("lat_daddr_e2", {27'd0, D_address}, 32'd5);
        check_eq("lat_ddata_e2", D_data, 32'h1234_5678);
        tick();
        check_eq("lat_write_e3", {31'd0, Write}, 32'd0);
        check_eq("lat_daddr_hold", {27'd0, D_address}, 32'd5);
        check_eq("lat_ddata_hold", D_data, 32'h1234_5678);
        check_eq("lat_idle_e3", {31'd0, idle}, 32'd1);

        // rd=0 load is accepted but never written.
        ld_valid = 1'b1;
        ld_rd    = 5'd0;
        ld_data  = 32'hDEAD_BEEF;
        check_eq("rd0_ld_ready", {31'd0, ld_ready}, 32'd1);
        tick();
        ld_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("rd0_write_%0d", k), {31'd0, Write}, 32'd0);
            check_eq($sformatf("rd0_idle_%0d", k), {31'd0, idle}, 32'd1);
            tick();
        end

        // Reset asserted mid-cycle with entries queued and a write on the port.
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0007;
        ld_valid  = 1'b1; ld_rd  = 5'd23; ld_data = 32'h0000_0017;
        tick();
        alu_rd = 5'd8;  alu_data = 32'h0000_0008;
        ld_rd  = 5'd24; ld_data  = 32'h0000_0018;
        tick();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        check_eq("prerst_write", {31'd0, Write}, 32'd1);
        check_eq("prerst_daddr", {27'd0, D_address}, 32'd23);
        #3;
        rst = 1'b1;
        #1;
        check_eq("midrst_write", {31'd0, Write}, 32'd0);
        check_eq("midrst_daddr", {27'd0, D_address}, 32'd0);
        check_eq("midrst_ddata", D_data, 32'd0);
        check_eq("midrst_alu_ready", {31'd0, alu_ready}, 32'd1);
        check_eq("midrst_ld_ready", {31'd0, ld_ready}, 32'd1);
        check_eq("midrst_idle", {31'd0, idle}, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check_eq("postrst_alu_ready", {31'd0, alu_ready}, 32'd1);
        check_eq("postrst_ld_ready", {31'd0, ld_ready}, 32'd1);
        check_eq("postrst_idle", {31'd0, idle}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq($sformatf("postrst_write_%0d", k), {31'd0, Write}, 32'd0);
            check_eq($sformatf("postrst_idle_%0d", k), {31'd0, idle}, 32'd1);
        end

`ifdef WB_BYPASS_EN
        alu_valid = 1'b1;
        alu_rd    = 5'd9;
        alu_data  = 32'hA5A5_A5A5;
        tick();
        alu_valid = 1'b0;
        tick();
        A_address = 5'd9;
        B_address = 5'd0;
        #1;
        check_eq("byp_write", {31'd0, Write}, 32'd1);
        check_eq("byp_a_fwd", {31'd0, A_fwd}, 32'd1);
        check_eq("byp_a_data", A_fwd_data, 32'hA5A5_A5A5);
        check_eq("byp_b_fwd", {31'd0, B_fwd}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

`default_nettype wire
